dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 53 +++++
 rtl/mem_lane_ext.sv | 31 +++
 rtl/dmem_responder.sv | 152 +++++++++++++++
 tb/tb_dmem_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared RISC-V memory-access types for the data-memory responder.
// Contents: load/store size encoding (funct3), responder FSM states,
// the captured request payload, and byte-lane helpers for stores.
package dmem_responder_pkg;

    localparam int unsigned XLEN = 32;

    // RISC-V load/store funct3 encoding; stores use only the signed codes
    typedef enum logic [2:0] {
        F3_B  = 3'd0,
        F3_H  = 3'd1,
        F3_W  = 3'd2,
        F3_BU = 3'd4,
        F3_HU = 3'd5
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic            we;
        logic [2:0]      funct3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } dmem_req_t;

    // Byte enables for a store of the given size at the given byte offset
    function automatic logic [3:0] store_mask(input logic [2:0] funct3, input logic [1:0] offset);
        logic [3:0] mask;
        case (mem_size_e'(funct3))
            F3_B:    mask = 4'b0001 << offset;
            F3_H:    mask = 4'b0011 << offset;
            F3_W:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Replicate right-aligned store data onto every lane it could target
    function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] funct3, input logic [XLEN-1:0] wdata);
        logic [XLEN-1:0] lanes;
        case (mem_size_e'(funct3))
            F3_B:    lanes = {4{wdata[7:0]}};
            F3_H:    lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/mem_lane_ext.sv
// Load lane select and sign/zero extension.
// Ports: word_i   - full 32-bit memory word
//        offset_i - byte offset within the word (addr[1:0])
//        funct3_i - RISC-V load size/sign code
//        data_c_o - extended load result (combinational)
module mem_lane_ext
    import dmem_responder_pkg::*;
(
    input  logic [XLEN-1:0] word_i,
    input  logic [1:0]      offset_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_c_o
);

    logic [XLEN-1:0] shifted_c;

    // Bring the addressed lane down to bit 0, then extend
    always_comb begin
        shifted_c = word_i >> {offset_i, 3'b000};
        data_c_o  = '0;
        case (mem_size_e'(funct3_i))
            F3_B:    data_c_o = {{24{shifted_c[7]}}, shifted_c[7:0]};
            F3_H:    data_c_o = {{16{shifted_c[15]}}, shifted_c[15:0]};
            F3_W:    data_c_o = shifted_c;
            F3_BU:   data_c_o = {24'h0, shifted_c[7:0]};
            F3_HU:   data_c_o = {16'h0, shifted_c[15:0]};
            default: data_c_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single-port word memory answering one
// load/store at a time after a programmable number of wait states.
// Ports: clk, rst (async, active-low)
//        req/we/funct3/addr/wdata - request, held by initiator until ack
//        ack   - one-cycle response strobe
//        rdata - extended load result, zero when ack is low
//        err   - access fault, qualified by ack
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            ack,
    output logic [XLEN-1:0] rdata,
    output logic            err
);

    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W    = 3;
    localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + 33'(4 * DEPTH_WORDS);

    dmem_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t       txn_q, txn_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];

    // Request under evaluation: live inputs while idle (zero-wait case), captured copy afterwards
    logic            cur_we_c;
    logic [2:0]      cur_f3_c;
    logic [XLEN-1:0] cur_addr_c;

    assign cur_we_c   = (state_q == ST_IDLE) ? we     : txn_q.we;
    assign cur_f3_c   = (state_q == ST_IDLE) ? funct3 : txn_q.funct3;
    assign cur_addr_c = (state_q == ST_IDLE) ? addr   : txn_q.addr;

    logic             in_range_c, misalign_c, illegal_c, fault_c;
    logic [IDX_W-1:0] idx_c;
    logic [XLEN-1:0]  load_c, resp_rdata_c;

    // Fault classification; range compared in 33 bits so the top of memory cannot wrap
    assign in_range_c = ({1'b0, cur_addr_c} >= 33'(BASE_ADDR)) && ({1'b0, cur_addr_c} < END_ADDR);
    assign misalign_c = ((cur_f3_c[1:0] == 2'd1) && cur_addr_c[0]) ||
                        ((cur_f3_c[1:0] == 2'd2) && (cur_addr_c[1:0] != 2'd0));
    assign illegal_c  = cur_we_c ? (cur_f3_c > 3'd2)
                                 : ((cur_f3_c == 3'd3) || (cur_f3_c >= 3'd6));
    assign fault_c    = !in_range_c || misalign_c || illegal_c;
    assign idx_c      = IDX_W'((cur_addr_c - BASE_ADDR) >> 2);

    mem_lane_ext u_lane_ext (
        .word_i   (mem_q[idx_c]),
        .offset_i (cur_addr_c[1:0]),
        .funct3_i (cur_f3_c),
        .data_c_o (load_c)
    );

    assign resp_rdata_c = (fault_c || cur_we_c) ? '0 : load_c;

    // Next-state and registered-output logic
    always_comb begin
        logic enter_resp;
        state_d    = state_q;
        cnt_d      = cnt_q;
        txn_d      = txn_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rdata_d    = '0;
        enter_resp = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    txn_d = '{we: we, funct3: funct3, addr: addr, wdata: wdata};
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (enter_resp) begin
            ack_d   = 1'b1;
            err_d   = fault_c;
            rdata_d = resp_rdata_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            txn_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            txn_q   <= txn_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Store commits on the edge leaving RESP; reset forces IDLE so an aborted store never lands
    logic            commit_c;
    logic [3:0]      st_mask_c;
    logic [XLEN-1:0] st_data_c;

    assign commit_c  = (state_q == ST_RESP) && txn_q.we && !err_q;
    assign st_mask_c = store_mask(txn_q.funct3, txn_q.addr[1:0]);
    assign st_data_c = store_lanes(txn_q.funct3, txn_q.wdata);

    // Memory contents survive reset
    always_ff @(posedge clk) begin
        if (commit_c) begin
            for (int b = 0; b < 4; b++) begin
                if (st_mask_c[b]) mem_q[idx_c][8*b +: 8] <= st_data_c[8*b +: 8];
            end
        end
    end

    assign ack   = ack_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, reset-abort
// and zero-wait back-to-back sequences, then random traffic against a
// byte-array reference model.
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        ack, err;
    logic [31:0] rdata;

    logic        req0, we0;
    logic [2:0]  funct30;
    logic [31:0] addr0, wdata0;
    logic        ack0, err0;
    logic [31:0] rdata0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mbytes [4*DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .ack(ack), .rdata(rdata), .err(err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .funct3(funct30), .addr(addr0),
        .wdata(wdata0), .ack(ack0), .rdata(rdata0), .err(err0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic preload(input int w, input logic [31:0] v);
        dut.mem_q[w]  = v;
        dut0.mem_q[w] = v;
        for (int b = 0; b < 4; b++) mbytes[4*w + b] = v[8*b +: 8];
    endtask

    // Reference: byte-addressed little-endian memory with the access rules applied directly
    function automatic void model_access(input logic m_we, input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int     size;
        longint off;
        longint val;
        rd = '0;
        er = 1'b0;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        off = longint'(a) - longint'(BASE);
        if (size == 0 || (m_we && f3 > 3'd2) || off < 0 || off >= 4*DEPTH || (a % size) != 0) begin
            er = 1'b1;
            return;
        end
        if (m_we) begin
            for (int i = 0; i < size; i++) mbytes[off + i] = wd[8*i +: 8];
        end else begin
            val = 0;
            for (int i = 0; i < size; i++) val += longint'(mbytes[off + i]) << (8*i);
            if (f3 < 3'd4 && size < 4 && val >= (longint'(1) << (8*size - 1)))
                val -= (longint'(1) << (8*size));
            rd = val[31:0];
        end
    endfunction

    // Issue one request (called just after a rising edge), hold req until ack, report latency
    task automatic do_txn(input string nm, input logic t_we, input logic [2:0] t_f3, input logic [31:0] t_addr,
                          input logic [31:0] t_wd, output logic [31:0] o_rd, output logic o_err, output int o_lat);
        req = 1'b1; we = t_we; funct3 = t_f3; addr = t_addr; wdata = t_wd;
        @(posedge clk);
        o_lat = 0; o_rd = '0; o_err = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ack) begin
                o_lat = i; o_rd = rdata; o_err = err;
                break;
            end
        end
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        chk({nm, " ack width"}, 32'(ack), 32'd0);
        chk({nm, " rdata idle"}, rdata, 32'd0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        int          off;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [23];

    initial begin
        logic [31:0] rd;
        logic        er, mer;
        logic [31:0] mrd;
        int          lat, acks;
        logic [31:0] exp0 [3];
        logic [31:0] adr0 [3];
        logic        exp_ack [7];
        int          k;

        vecs[0]  = '{1'b0, 3'd2,   8, 32'h0,        32'hdeadbeef, 1'b0};
        vecs[1]  = '{1'b0, 3'd0,  11, 32'h0,        32'hffffffde, 1'b0};
        vecs[2]  = '{1'b0, 3'd4,  11, 32'h0,        32'h000000de, 1'b0};
        vecs[3]  = '{1'b0, 3'd1,  10, 32'h0,        32'hffffdead, 1'b0};
        vecs[4]  = '{1'b0, 3'd5,   8, 32'h0,        32'h0000beef, 1'b0};
        vecs[5]  = '{1'b1, 3'd0,   9, 32'h000000aa, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 3'd2,   8, 32'h0,        32'hdeadaaef, 1'b0};
        vecs[7]  = '{1'b1, 3'd1,  10, 32'h00001234, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 3'd2,   8, 32'h0,        32'h1234aaef, 1'b0};
        vecs[9]  = '{1'b0, 3'd2,   6, 32'h0,        32'h0,        1'b1};
        vecs[10] = '{1'b0, 3'd1,   3, 32'h0,        32'h0,        1'b1};
        vecs[11] = '{1'b0, 3'd2, 256, 32'h0,        32'h0,        1'b1};
        vecs[12] = '{1'b1, 3'd2,  -4, 32'hffffffff, 32'h0,        1'b1};
        vecs[13] = '{1'b0, 3'd2, 252, 32'h0,        32'h5a5a0001, 1'b0};
        vecs[14] = '{1'b1, 3'd2, 256, 32'h11111111, 32'h0,        1'b1};
        vecs[15] = '{1'b0, 3'd3,   8, 32'h0,        32'h0,        1'b1};
        vecs[16] = '{1'b1, 3'd4,   8, 32'h0,        32'h0,        1'b1};
        vecs[17] = '{1'b1, 3'd1,   9, 32'h0000ffff, 32'h0,        1'b1};
        vecs[18] = '{1'b0, 3'd2,   8, 32'h0,        32'h1234aaef, 1'b0};
        vecs[19] = '{1'b0, 3'd2, 252, 32'h0,        32'h5a5a0001, 1'b0};
        vecs[20] = '{1'b0, 3'd0,   8, 32'h0,        32'hffffffef, 1'b0};
        vecs[21] = '{1'b0, 3'd5,  10, 32'h0,        32'h00001234, 1'b0};
        vecs[22] = '{1'b0, 3'd7,   8, 32'h0,        32'h0,        1'b1};

        rst = 1'b0;
        req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = '0; wdata = '0;
        req0 = 1'b0; we0 = 1'b0; funct30 = 3'd2; addr0 = '0; wdata0 = '0;

        for (int w = 0; w < DEPTH; w++) preload(w, $urandom);
        preload(2, 32'hdeadbeef);
        preload(3, 32'h0badf00d);
        preload(DEPTH - 1, 32'h5a5a0001);

        @(negedge clk);
        chk("reset ack", 32'(ack), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset rdata", rdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Zero-wait instance: req held across three loads, ack every other cycle
        adr0[0] = BASE + 32'd8;   exp0[0] = 32'hdeadbeef;
        adr0[1] = BASE + 32'd12;  exp0[1] = 32'h0badf00d;
        adr0[2] = BASE + 32'd252; exp0[2] = 32'h5a5a0001;
        exp_ack = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        k = 0;
        req0 = 1'b1; addr0 = adr0[0];
        @(posedge clk);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk($sformatf("b2b ack cyc%0d", c), 32'(ack0), 32'(exp_ack[c]));
            if (ack0 && k < 3) begin
                chk($sformatf("b2b rdata %0d", k), rdata0, exp0[k]);
                chk($sformatf("b2b err %0d", k), 32'(err0), 32'd0);
                k++;
                if (k < 3) addr0 = adr0[k];
                else req0 = 1'b0;
            end
        end
        req0 = 1'b0;
        @(posedge clk);
        #1;

        // Directed table on the one-wait instance
        for (int i = 0; i < 23; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, BASE + 32'(vecs[i].off), vecs[i].wd, rd, er, lat);
            chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
            model_access(vecs[i].we, vecs[i].f3, BASE + 32'(vecs[i].off), vecs[i].wd, mrd, mer);
        end

        // Reset during WAIT aborts a store; first request afterwards is served
        req = 1'b1; we = 1'b1; funct3 = 3'd2; addr = BASE + 32'd12; wdata = 32'hc001c0de;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst mid ack", 32'(ack), 32'd0);
        chk("rst mid rdata", rdata, 32'd0);
        req = 1'b0;
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            acks += int'(ack);
        end
        chk("rst abort acks", 32'(acks), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        do_txn("post rst", 1'b0, 3'd2, BASE + 32'd12, 32'h0, rd, er, lat);
        chk("post rst rdata", rd, 32'h0badf00d);
        chk("post rst err", 32'(er), 32'd0);
        chk("post rst latency", 32'(lat), 32'd2);

        // Random traffic against the reference model
        for (int n = 0; n < 200; n++) begin
            logic        r_we;
            logic [2:0]  r_f3;
            logic [31:0] r_addr, r_wd;
            int          legal_codes [5];
            legal_codes = '{0, 1, 2, 4, 5};
            r_we   = 1'($urandom_range(0, 1));
            r_f3   = ($urandom_range(0, 3) != 0) ? 3'(legal_codes[$urandom_range(0, 4)]) : 3'($urandom_range(0, 7));
            r_addr = BASE + 32'(int'($urandom_range(0, 4*DEPTH + 15)) - 8);
            r_wd   = $urandom;
            model_access(r_we, r_f3, r_addr, r_wd, mrd, mer);
            do_txn($sformatf("rnd%0d", n), r_we, r_f3, r_addr, r_wd, rd, er, lat);
            chk($sformatf("rnd%0d rdata a=%h f3=%0d we=%0d", n, r_addr, r_f3, r_we), rd, mrd);
            chk($sformatf("rnd%0d err", n), 32'(er), 32'(mer));
            chk($sformatf("rnd%0d latency", n), 32'(lat), 32'd2);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
